// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with mid-bit sampling.
// A falling edge on the synchronized line starts a frame. The line is then
// sampled once per bit period (start, eight data bits LSB first, stop).
// A byte is published with a one-cycle rx_end strobe only when the stop bit is high.
module uart_rx_core #(
  parameter int DIV_RATE  = 260,
  parameter int DIV_CNT_W = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_busy,
  output logic       rx_end,
  output logic [7:0] rx_data
);

  typedef enum logic {IDLE, RX} state_t;

  localparam logic [DIV_CNT_W-1:0] HALF_DIV    = DIV_CNT_W'(DIV_RATE / 2);
  localparam logic [DIV_CNT_W-1:0] FULL_DIV_M1 = DIV_CNT_W'(DIV_RATE - 1);
  localparam logic [DIV_CNT_W-1:0] DIV_ONE     = DIV_CNT_W'(1);
  localparam logic [3:0]           STOP_IDX    = 4'd9;

  logic                 rx_meta_q, rx_s_q, rx_s_dly_q;
  state_t               state_q, state_d;
  logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 rx_busy_q, rx_busy_d;
  logic                 rx_end_q, rx_end_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 start_edge;
  logic                 sample_now;

  // Only a 1->0 transition starts a frame, so a line held low cannot retrigger.
  assign start_edge = rx_s_dly_q & ~rx_s_q;
  assign sample_now = (state_q == RX) && (div_cnt_q == '0);

  // Two-flop synchronizer plus one delay stage for edge detection; all idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_s_dly_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_s_dly_q <= rx_s_q;
    end
  end

  // State register together with the counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_busy_q <= 1'b0;
      rx_end_q  <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_busy_q <= rx_busy_d;
      rx_end_q  <= rx_end_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Next state: leave RX on a false start bit or after the stop-bit sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_edge) state_d = RX;
      end
      RX: begin
        if (sample_now) begin
          if ((bit_cnt_q == 4'd0) && rx_s_q) state_d = IDLE;
          else if (bit_cnt_q == STOP_IDX)     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs: bit timing, byte assembly and the publish strobe.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rx_end_d  = 1'b0;
    rx_busy_d = (state_d == RX);
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          div_cnt_d = HALF_DIV;
          bit_cnt_d = 4'd0;
        end
      end
      RX: begin
        if (sample_now) begin
          div_cnt_d = FULL_DIV_M1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == STOP_IDX) begin
            // Publish only a correctly framed byte; a low stop bit drops it.
            if (rx_s_q) begin
              rx_data_d = shift_q;
              rx_end_d  = 1'b1;
            end
          end else if (bit_cnt_q != 4'd0) begin
            // Shifting in from the top leaves data bit k-1 at position k-1.
            shift_d = {rx_s_q, shift_q[7:1]};
          end
        end else begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end
      end
      default: ;
    endcase
  end

  assign rx_busy = rx_busy_q;
  assign rx_end  = rx_end_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed checks of uart_rx_core at DIV_RATE=16 and DIV_RATE=260.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset16 = 1'b1, rx16 = 1'b1;
  logic       rx_busy16, rx_end16;
  logic [7:0] rx_data16;
  logic       reset260 = 1'b1, rx260 = 1'b1;
  logic       rx_busy260, rx_end260;
  logic [7:0] rx_data260;

  always #5 clk = ~clk;

  uart_rx_core #(.DIV_RATE(16), .DIV_CNT_W(9)) u_dut16 (
    .clk(clk), .reset(reset16), .rx(rx16),
    .rx_busy(rx_busy16), .rx_end(rx_end16), .rx_data(rx_data16)
  );

  uart_rx_core #(.DIV_RATE(260), .DIV_CNT_W(9)) u_dut260 (
    .clk(clk), .reset(reset260), .rx(rx260),
    .rx_busy(rx_busy260), .rx_end(rx_end260), .rx_data(rx_data260)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Monitor state for the DIV_RATE=16 instance (sampled on the falling edge).
  int         cyc = 0;
  int         strobes16 = 0, busy_starts16 = 0;
  int         busy_run16 = 0, last_busy_len16 = 0;
  int         last_strobe_cyc16 = 0, prev_strobe_cyc16 = 0;
  logic [7:0] last_strobe_data16 = 8'h00, prev_strobe_data16 = 8'h00;
  int         width_err16 = 0, overlap_err16 = 0, data_chg_err16 = 0;
  logic       prev_end16 = 1'b0, prev_busy16 = 1'b0;
  logic [7:0] prev_data16 = 8'h00;
  int         strobes260 = 0, overlap_err260 = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_end16) begin
      strobes16          <= strobes16 + 1;
      prev_strobe_cyc16  <= last_strobe_cyc16;
      last_strobe_cyc16  <= cyc;
      prev_strobe_data16 <= last_strobe_data16;
      last_strobe_data16 <= rx_data16;
      if (prev_end16) width_err16 <= width_err16 + 1;
      if (rx_busy16) overlap_err16 <= overlap_err16 + 1;
    end
    if (!reset16 && (rx_data16 != prev_data16) && !rx_end16)
      data_chg_err16 <= data_chg_err16 + 1;
    if (rx_busy16 && !prev_busy16) busy_starts16 <= busy_starts16 + 1;
    if (rx_busy16) busy_run16 <= busy_run16 + 1;
    else if (busy_run16 != 0) begin
      last_busy_len16 <= busy_run16;
      busy_run16      <= 0;
    end
    prev_end16  <= rx_end16;
    prev_busy16 <= rx_busy16;
    prev_data16 <= rx_data16;
    if (rx_end260) begin
      strobes260 <= strobes260 + 1;
      if (rx_busy260) overlap_err260 <= overlap_err260 + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic b, input int n);
    if (sel) rx260 = b;
    else     rx16  = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop_b);
    int n;
    n = sel ? 260 : 16;
    drive_bit(sel, 1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], n);
    drive_bit(sel, stop_b, n);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    int         exp_strobes;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0, b0, len;

    vecs[0] = '{8'h41, 1'b1, 1, 8'h41};
    vecs[1] = '{8'h00, 1'b1, 1, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0, 8'hFF};
    vecs[4] = '{8'hA5, 1'b1, 1, 8'hA5};
    vecs[5] = '{8'h80, 1'b1, 1, 8'h80};

    // Reset held 20 cycles, then 1000 idle cycles with no activity.
    repeat (20) @(negedge clk);
    check("reset_busy", {31'b0, rx_busy16}, 32'd0);
    check("reset_end", {31'b0, rx_end16}, 32'd0);
    check("reset_data", {24'b0, rx_data16}, 32'h00);
    reset16 = 1'b0;
    repeat (1000) @(negedge clk);
    check("idle_strobes", strobes16, 0);
    check("idle_busy_starts", busy_starts16, 0);
    check("idle_data", {24'b0, rx_data16}, 32'h00);
    $display("idle: strobes=%0d rx_data=%h", strobes16, rx_data16);

    // Table of single frames separated by an idle gap.
    for (int v = 0; v < 6; v++) begin
      drive_bit(1'b0, 1'b1, 20);
      s0 = strobes16;
      send_frame(1'b0, vecs[v].data, vecs[v].stop_b);
      drive_bit(1'b0, 1'b1, 10);
      len = last_busy_len16;
      $display("vec %0d: sent=%h stop=%0b strobes=%0d rx_data=%h busy_len=%0d",
               v, vecs[v].data, vecs[v].stop_b, strobes16 - s0, rx_data16, len);
      check($sformatf("vec%0d_strobes", v), strobes16 - s0, vecs[v].exp_strobes);
      check($sformatf("vec%0d_data", v), {24'b0, rx_data16}, {24'b0, vecs[v].exp_data});
      check($sformatf("vec%0d_busy_idle", v), {31'b0, rx_busy16}, 32'd0);
      check($sformatf("vec%0d_busy_len", v), {31'b0, (len >= 150 && len <= 156)}, 32'd1);
    end

    // Back-to-back 0x55 then 0xAA with no idle gap.
    drive_bit(1'b0, 1'b1, 20);
    s0 = strobes16;
    send_frame(1'b0, 8'h55, 1'b1);
    send_frame(1'b0, 8'hAA, 1'b1);
    drive_bit(1'b0, 1'b1, 10);
    $display("b2b: strobes=%0d first=%h second=%h gap=%0d", strobes16 - s0,
             prev_strobe_data16, last_strobe_data16, last_strobe_cyc16 - prev_strobe_cyc16);
    check("b2b_strobes", strobes16 - s0, 2);
    check("b2b_first", {24'b0, prev_strobe_data16}, 32'h55);
    check("b2b_second", {24'b0, last_strobe_data16}, 32'hAA);
    check("b2b_gap", {31'b0, ((last_strobe_cyc16 - prev_strobe_cyc16) >= 158 &&
                              (last_strobe_cyc16 - prev_strobe_cyc16) <= 162)}, 32'd1);

    // Three-cycle low glitch: short busy, no strobe, data kept.
    s0 = strobes16;
    b0 = busy_starts16;
    drive_bit(1'b0, 1'b0, 3);
    drive_bit(1'b0, 1'b1, 20);
    len = last_busy_len16;
    $display("glitch: busy_starts=%0d busy_len=%0d strobes=%0d rx_data=%h",
             busy_starts16 - b0, len, strobes16 - s0, rx_data16);
    check("glitch_busy_started", busy_starts16 - b0, 1);
    check("glitch_busy_len", {31'b0, (len >= 1 && len <= 12)}, 32'd1);
    check("glitch_strobes", strobes16 - s0, 0);
    check("glitch_data", {24'b0, rx_data16}, 32'hAA);

    // Framing error on 0x3C, line then held low (break), then 0x7E.
    s0 = strobes16;
    b0 = busy_starts16;
    send_frame(1'b0, 8'h3C, 1'b0);
    drive_bit(1'b0, 1'b0, 20);
    check("break_busy", {31'b0, rx_busy16}, 32'd0);
    drive_bit(1'b0, 1'b0, 20);
    drive_bit(1'b0, 1'b1, 30);
    $display("framing: strobes=%0d busy_starts=%0d rx_data=%h",
             strobes16 - s0, busy_starts16 - b0, rx_data16);
    check("frm_strobes", strobes16 - s0, 0);
    check("frm_no_retrigger", busy_starts16 - b0, 1);
    check("frm_data", {24'b0, rx_data16}, 32'hAA);
    send_frame(1'b0, 8'h7E, 1'b1);
    drive_bit(1'b0, 1'b1, 10);
    $display("after_break: strobes=%0d rx_data=%h", strobes16 - s0, rx_data16);
    check("7e_strobes", strobes16 - s0, 1);
    check("7e_data", {24'b0, rx_data16}, 32'h7E);

    // DIV_RATE=260: good frame, then reset in the middle of 0xF0, then 0x0F.
    reset260 = 1'b0;
    drive_bit(1'b1, 1'b1, 20);
    s0 = strobes260;
    send_frame(1'b1, 8'hA5, 1'b1);
    drive_bit(1'b1, 1'b1, 20);
    $display("div260 first: strobes=%0d rx_data=%h", strobes260 - s0, rx_data260);
    check("d260_a5_strobes", strobes260 - s0, 1);
    check("d260_a5_data", {24'b0, rx_data260}, 32'hA5);
    s0 = strobes260;
    drive_bit(1'b1, 1'b0, 260);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 260);
    drive_bit(1'b1, 1'b1, 130);
    check("d260_busy_before_rst", {31'b0, rx_busy260}, 32'd1);
    #2 reset260 = 1'b1;
    #1;
    $display("div260 reset: busy=%0b end=%0b rx_data=%h", rx_busy260, rx_end260, rx_data260);
    check("d260_rst_busy", {31'b0, rx_busy260}, 32'd0);
    check("d260_rst_end", {31'b0, rx_end260}, 32'd0);
    check("d260_rst_data", {24'b0, rx_data260}, 32'h00);
    rx260 = 1'b1;
    repeat (3) @(negedge clk);
    reset260 = 1'b0;
    drive_bit(1'b1, 1'b1, 300);
    check("d260_no_strobe", strobes260 - s0, 0);
    send_frame(1'b1, 8'h0F, 1'b1);
    drive_bit(1'b1, 1'b1, 20);
    $display("div260 after reset: strobes=%0d rx_data=%h", strobes260 - s0, rx_data260);
    check("d260_0f_strobes", strobes260 - s0, 1);
    check("d260_0f_data", {24'b0, rx_data260}, 32'h0F);

    // Invariants gathered by the monitor across the whole run.
    check("end_width", width_err16, 0);
    check("end_vs_busy16", overlap_err16, 0);
    check("end_vs_busy260", overlap_err260, 0);
    check("data_only_on_end", data_chg_err16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
